program_loader: RTL and testbench
=================================

# program_loader

Boot-time front end for the 8-bit accumulator CPU. It holds the CPU in reset and accepts a byte stream of exactly 32 bytes. Each byte is written into consecutive CPU memory cells 0..31. The loader then releases the CPU, counts execution cycles until the CPU raises halt, and reports done, timeout and the cycle count. It sits upstream of the CPU top level. While the CPU is held in reset, its write port is muxed onto the CPU memory port.

## Interface
- ADDR_W, 5, memory address width; depth = 2**ADDR_W = 32
- DATA_W, 8, memory/stream data width
- RUN_TIMEOUT, 1000, maximum RUN cycles before abort; range 1..65535

- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  begin a load; sampled only in IDLE or DONE
- in_valid  in  1  stream byte valid
- in_data  in  DATA_W  stream byte
- in_ready  out  1  loader accepts byte this cycle
- mem_wr  out  1  memory write strobe, registered
- mem_addr  out  ADDR_W  write address, registered
- mem_wdata  out  DATA_W  write data, registered
- cpu_rst  out  1  active-low reset to CPU, registered; low = CPU held
- halt  in  1  CPU halt_out
- busy  out  1  state is LOAD, SETTLE or RUN
- done  out  1  run finished (halt or timeout)
- timeout  out  1  run aborted by RUN_TIMEOUT
- cycles  out  16  RUN cycle count, frozen in DONE

## Operation
- Reset values:
  - state IDLE
  - in_ready 0, mem_wr 0, mem_addr 0, mem_wdata 0
  - cpu_rst 0, busy 0, done 0, timeout 0, cycles 0
- States: IDLE, LOAD, SETTLE, RUN, DONE.
- IDLE: start=1 → LOAD. On the transition, the address counter clears to 0, done and timeout clear, and cpu_rst is driven 0.
- LOAD:
  - in_ready = 1; it is decoded from the state.
  - A handshake is in_valid & in_ready.
  - On each handshake, the next cycle has mem_wr=1, mem_addr=counter, mem_wdata=in_data; the counter then increments.
  - No handshake → mem_wr=0 next cycle.
  - The handshake at counter 31 → SETTLE. The counter wraps to 0 and is not reused.
- SETTLE: one cycle. The final write is presented (mem_wr=1, addr 31). Next state is RUN, and cpu_rst goes 1 at that edge. cycles clears to 0.
- RUN:
  - halt=1 → DONE with done=1; cycles unchanged.
  - halt=0 and cycles==RUN_TIMEOUT-1 → cycles increments to RUN_TIMEOUT, then DONE with done=1, timeout=1, cpu_rst=0.
  - Otherwise cycles increments by 1.
- DONE:
  - done holds. On a halt finish, cpu_rst stays 1 so the halted CPU state remains observable. On a timeout, cpu_rst stays 0.
  - start=1 → LOAD, with the same clears as from IDLE.
- Ignored inputs:
  - start in LOAD, SETTLE or RUN is ignored.
  - halt outside RUN is ignored.
  - in_valid outside LOAD is ignored (in_ready=0).
- Width rules:
  - cycles is 16-bit unsigned and never exceeds RUN_TIMEOUT, so it cannot wrap.
  - mem_addr wraps modulo 32.
- Reset asserted mid-operation: all outputs return to reset values immediately (asynchronously). cpu_rst=0 therefore re-holds the CPU. A partial load is discarded.

## Timing
- Stream handshake: zero-latency; a byte is accepted in the same cycle that valid and ready are both high. Back-to-back bytes are accepted every cycle.
- Write latency: 1 cycle from handshake to mem_wr.
- Minimum load time: 32 cycles in LOAD plus 1 cycle in SETTLE. With continuous valid, cpu_rst rises 33 edges after the start edge.
- halt is sampled every RUN cycle. DONE is entered on the edge after halt is seen high, and cycles equals the number of RUN cycles in which halt was low.
- Top level requirement: memory writes are taken from the loader whenever cpu_rst=0. The mux select is cpu_rst.

## Structure
- Shared package cpu_pkg:
  - ADDR_W, DATA_W and DEPTH constants, also used by the memory/pc/ir widths.
  - loader_state_t enum {IDLE, LOAD, SETTLE, RUN, DONE}.
- One sub-module, run_counter:
  - 16-bit counter with clear, enable and terminal-compare against RUN_TIMEOUT.
  - Outputs count and at_limit.
- The FSM, address counter and write register live in program_loader.

## Test plan
- Reset then idle: rst low mid-stream → all outputs 0 immediately; after release, in_ready=0 until start.
- Full load, continuous valid:
  - Stimulus: start, then bytes 0x00..0x1F.
  - Required: 32 mem_wr pulses with addr n, data n.
  - Required: cpu_rst rises exactly 33 edges after start; busy=1 throughout.
- Gapped stream: in_valid toggling 1,0,1,… with 32 bytes → addresses contiguous 0..31 with no skipped or duplicate writes; mem_wr=0 on gap cycles.
- Halt finish:
  - Stimulus: program HALT at address 5.
  - Required: done=1, timeout=0, cycles equals the CPU's halt cycle count.
  - Required: cpu_rst stays 1 and cycles stays frozen for 20 cycles.
- Timeout: RUN_TIMEOUT=50 with a JMP-to-self program → done=1, timeout=1, cycles=50, cpu_rst=0.
- Restart and ignored start:
  - start pulses during RUN are ignored.
  - start in DONE → LOAD with done=0, timeout=0, and a new load beginning at address 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared constants and types for the accumulator CPU and its boot loader.
// Memory/pc/ir widths elsewhere in the CPU derive from ADDR_W and DATA_W.
package cpu_pkg;

    localparam int ADDR_W  = 5;
    localparam int DATA_W  = 8;
    localparam int DEPTH   = 1 << ADDR_W;
    localparam int CYCLE_W = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        SETTLE = 3'd2,
        RUN    = 3'd3,
        DONE   = 3'd4
    } loader_state_t;

endpackage

// File: rtl/program_loader_run_counter.sv
// RUN-phase cycle counter with synchronous clear, count enable and a
// terminal compare that flags the last cycle before the timeout limit.
module run_counter #(
    parameter int WIDTH = 16,
    parameter int LIMIT = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             at_limit
);

    // The loader leaves RUN on the increment to LIMIT, so count never wraps.
    assign at_limit = (count == WIDTH'(LIMIT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/program_loader.sv
// Boot front end: holds the CPU in reset, streams 32 bytes into memory,
// then releases the CPU and times its run until halt or timeout.
module program_loader
    import cpu_pkg::*;
#(
    parameter int RUN_TIMEOUT = 1000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               in_valid,
    input  logic [DATA_W-1:0]  in_data,
    output logic               in_ready,
    output logic               mem_wr,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [DATA_W-1:0]  mem_wdata,
    output logic               cpu_rst,
    input  logic               halt,
    output logic               busy,
    output logic               done,
    output logic               timeout,
    output logic [CYCLE_W-1:0] cycles,
    output loader_state_t      state
);

    // Stream handshake: a byte transfers in any cycle where in_valid and
    // in_ready are both high; in_ready is high exactly while in LOAD.
    logic [ADDR_W-1:0] addr_cnt;
    logic              handshake;
    logic              cnt_clr;
    logic              cnt_en;
    logic              at_limit;

    assign in_ready  = (state == LOAD);
    assign handshake = in_valid & in_ready;
    assign busy      = (state == LOAD) || (state == SETTLE) || (state == RUN);
    assign cnt_clr   = (state == SETTLE);
    assign cnt_en    = (state == RUN) && !halt;

    run_counter #(
        .WIDTH (CYCLE_W),
        .LIMIT (RUN_TIMEOUT)
    ) u_run_counter (
        .clk      (clk),
        .rst      (rst),
        .clr      (cnt_clr),
        .en       (cnt_en),
        .count    (cycles),
        .at_limit (at_limit)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            addr_cnt  <= '0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_rst   <= 1'b0;
            done      <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            mem_wr <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state    <= LOAD;
                        addr_cnt <= '0;
                        done     <= 1'b0;
                        timeout  <= 1'b0;
                        cpu_rst  <= 1'b0;
                    end
                end
                LOAD: begin
                    if (handshake) begin
                        mem_wr    <= 1'b1;
                        mem_addr  <= addr_cnt;
                        mem_wdata <= in_data;
                        addr_cnt  <= addr_cnt + ADDR_W'(1);
                        if (addr_cnt == ADDR_W'(DEPTH - 1)) begin
                            state <= SETTLE;
                        end
                    end
                end
                SETTLE: begin
                    // Last write is on the memory port this cycle; release the CPU after it.
                    state   <= RUN;
                    cpu_rst <= 1'b1;
                end
                RUN: begin
                    if (halt) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else if (at_limit) begin
                        state   <= DONE;
                        done    <= 1'b1;
                        timeout <= 1'b1;
                        cpu_rst <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: randomized loads and runs checked against a
// scoreboard of expected memory writes and a cycle-level run model.
module tb_program_loader;
    import cpu_pkg::*;

    localparam int RUN_TO = 50;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               start = 1'b0;
    logic               in_valid = 1'b0;
    logic [DATA_W-1:0]  in_data = '0;
    logic               halt = 1'b0;
    logic               in_ready;
    logic               mem_wr;
    logic [ADDR_W-1:0]  mem_addr;
    logic [DATA_W-1:0]  mem_wdata;
    logic               cpu_rst;
    logic               busy;
    logic               done;
    logic               timeout;
    logic [CYCLE_W-1:0] cycles;
    loader_state_t      state;

    int checks = 0;
    int failures = 0;
    logic [ADDR_W+DATA_W-1:0] exp_q[$];
    int wr_hits[DEPTH];

    program_loader #(.RUN_TIMEOUT(RUN_TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_rst   (cpu_rst),
        .halt      (halt),
        .busy      (busy),
        .done      (done),
        .timeout   (timeout),
        .cycles    (cycles),
        .state     (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_mem_wr"}, mem_wr, 0);
        check({tag, "_mem_addr"}, mem_addr, 0);
        check({tag, "_mem_wdata"}, mem_wdata, 0);
        check({tag, "_cpu_rst"}, cpu_rst, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_timeout"}, timeout, 0);
        check({tag, "_cycles"}, cycles, 0);
        check({tag, "_state"}, state, IDLE);
    endtask

    task automatic check_write(input logic exp_wr);
        logic [ADDR_W+DATA_W-1:0] e;
        check("mem_wr", mem_wr, exp_wr);
        if (mem_wr === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("sb_depth", exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                check("mem_addr", mem_addr, e[ADDR_W+DATA_W-1:DATA_W]);
                check("mem_wdata", mem_wdata, e[DATA_W-1:0]);
                wr_hits[mem_addr]++;
            end
        end
    endtask

    // mode 0: continuous valid with data n; mode 1: valid 1,0,1,...; mode 2: random gaps/data and start pokes
    task automatic load_image(input int mode);
        int sent = 0;
        int guard = 0;
        int bad = 0;
        logic hs = 1'b0;
        logic v;
        logic [DATA_W-1:0] d;
        exp_q.delete();
        foreach (wr_hits[i]) wr_hits[i] = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_done_clr", done, 0);
        check("start_timeout_clr", timeout, 0);
        check("start_state", state, LOAD);
        while (sent < DEPTH && guard < 400) begin
            check_write(hs);
            check("load_in_ready", in_ready, 1);
            check("load_busy", busy, 1);
            check("load_cpu_rst", cpu_rst, 0);
            if (mode == 0) v = 1'b1;
            else if (mode == 1) v = (guard % 2 == 0);
            else v = ($urandom_range(0, 2) != 0);
            d = (mode == 0) ? DATA_W'(sent) : DATA_W'($urandom);
            start = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            in_valid = v;
            in_data = d;
            hs = v;
            if (v) begin
                exp_q.push_back({ADDR_W'(sent), d});
                sent++;
            end
            guard++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        start = 1'b0;
        check("load_bound", sent, DEPTH);
        check_write(hs);
        check("settle_state", state, SETTLE);
        check("settle_in_ready", in_ready, 0);
        check("settle_busy", busy, 1);
        check("settle_cpu_rst", cpu_rst, 0);
        if (mode == 0) check("load_edges", guard + 1, DEPTH + 1);
        @(negedge clk);
        check_write(1'b0);
        check("run_state", state, RUN);
        check("run_cpu_rst", cpu_rst, 1);
        check("run_cycles0", cycles, 0);
        check("sb_left", exp_q.size(), 0);
        foreach (wr_hits[i]) if (wr_hits[i] != 1) bad++;
        check("wr_coverage", bad, 0);
    endtask

    // CPU stand-in: halt rises after halt_after low RUN cycles unless the timeout comes first
    task automatic run_program(input int halt_after, input bit poke);
        int k = 0;
        int exp_cyc = 0;
        logic exp_to = 1'b0;
        bit fin = 1'b0;
        for (int c = 0; c < RUN_TO + 2 && !fin; c++) begin
            check("run_cycles", cycles, k);
            check("run_done", done, 0);
            check("run_busy", busy, 1);
            halt = (k == halt_after);
            start = poke ? 1'($urandom_range(0, 1)) : 1'b0;
            if (halt) begin
                exp_cyc = k;
                exp_to = 1'b0;
                fin = 1'b1;
            end else if (k == RUN_TO - 1) begin
                exp_cyc = RUN_TO;
                exp_to = 1'b1;
                fin = 1'b1;
            end else begin
                k++;
            end
            @(negedge clk);
        end
        start = 1'b0;
        halt = 1'b0;
        check("run_bound", fin, 1);
        check("fin_done", done, 1);
        check("fin_timeout", timeout, exp_to);
        check("fin_cycles", cycles, exp_cyc);
        check("fin_cpu_rst", cpu_rst, !exp_to);
        check("fin_busy", busy, 0);
        check("fin_state", state, DONE);
        for (int i = 0; i < 20; i++) begin
            halt = 1'($urandom_range(0, 1));
            in_valid = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("hold_done", done, 1);
            check("hold_cycles", cycles, exp_cyc);
            check("hold_cpu_rst", cpu_rst, !exp_to);
            check("hold_in_ready", in_ready, 0);
            check("hold_mem_wr", mem_wr, 0);
        end
        halt = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        #1;
        check_all_zero("por");
        @(negedge clk);
        rst = 1'b1;

        // Partial load, then asynchronous reset between edges
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data = DATA_W'($urandom);
            @(negedge clk);
        end
        check("partial_busy", busy, 1);
        #2;
        rst = 1'b0;
        #1;
        check_all_zero("async_rst");
        in_valid = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("idle_in_ready", in_ready, 0);
            check("idle_mem_wr", mem_wr, 0);
            check("idle_busy", busy, 0);
            check("idle_cpu_rst", cpu_rst, 0);
        end
        in_valid = 1'b0;

        load_image(0);
        run_program($urandom_range(3, 40), 1'b1);

        load_image(1);
        run_program(1000, 1'b1);

        load_image(2);
        run_program(RUN_TO - 1, 1'b0);

        load_image(2);
        run_program(0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
